// File: rtl/nonce_serial_fifo.sv
// Queues winning nonces from the hash core and shifts them to the host one bit per
// readready cycle, with frame start marking, occupancy flags and saturating drop counting.
module nonce_serial_fifo #(
    parameter int NONCE_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int DROP_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic                       success,
    input  logic [NONCE_WIDTH-1:0]     nonce_i,
    input  logic                       readready,
    output logic                       nonce_o,
    output logic                       nonce_valid,
    output logic                       sof,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(NONCE_WIDTH);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_BIT  = PW'(NONCE_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [AW-1:0]          head_q, head_d;
    logic [AW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   nonce_o_q, nonce_o_d;
    logic                   nonce_valid_q, nonce_valid_d;
    logic                   sof_q, sof_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic [NONCE_WIDTH-1:0] mem_q [DEPTH];

    logic [NONCE_WIDTH-1:0] head_word;
    logic [PW-1:0]          bit_idx;
    logic                   emit;
    logic                   pop;
    logic                   push_req;
    logic                   push;

    // A pop on this edge frees a slot, so a full FIFO still accepts a capture then.
    always_comb begin
        head_word = mem_q[head_q];
        bit_idx   = MSB_FIRST ? (LAST_BIT - ptr_q) : ptr_q;
        push_req  = valid && success;
        emit      = readready && (count_q != '0);
        pop       = emit && (ptr_q == LAST_BIT);
        push      = push_req && ((count_q != FULL_CNT) || pop);
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        nonce_o_d     = 1'b0;
        nonce_valid_d = 1'b0;
        sof_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (emit) begin
                    state_d = S_ACTIVE;
                    ptr_d   = PW'(1);
                end
            end
            S_ACTIVE: begin
                if (emit) begin
                    if (pop) begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
        if (emit) begin
            nonce_o_d     = head_word[bit_idx];
            nonce_valid_d = 1'b1;
            sof_d         = (ptr_q == '0);
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (pop) begin
            head_d = (head_q == LAST_SLOT) ? '0 : head_q + AW'(1);
        end
        if (push) begin
            tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (push_req && !push) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            nonce_o_q     <= 1'b0;
            nonce_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            overflow_q    <= 1'b0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            nonce_o_q     <= nonce_o_d;
            nonce_valid_q <= nonce_valid_d;
            sof_q         <= sof_d;
            overflow_q    <= overflow_d;
            drop_q        <= drop_d;
        end
    end

    // Storage is not reset; count gates every read so stale contents are never shifted out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= nonce_i;
        end
    end

    assign nonce_o     = nonce_o_q;
    assign nonce_valid = nonce_valid_q;
    assign sof         = sof_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_nonce_serial_fifo.sv
// Bench: two instances (LSB-first depth 4, MSB-first depth 3 with a 2-bit drop counter)
// share one stimulus stream and are checked every cycle against a queue-based model.
module tb_nonce_serial_fifo;
    logic        clk;
    logic        rst;
    logic        valid;
    logic        success;
    logic [31:0] nonce_i;
    logic        readready;

    logic       a_o, a_v, a_sof, a_empty, a_full, a_ovf;
    logic [2:0] a_count;
    logic [7:0] a_drop;
    logic       b_o, b_v, b_sof, b_empty, b_full, b_ovf;
    logic [1:0] b_count;
    logic [1:0] b_drop;

    int errors = 0;
    int checks = 0;

    // Model: one queue of whole nonces per instance plus the index of the next bit to send.
    logic [31:0] mq[2][$];
    int          mbit[2];
    logic        m_o[2];
    logic        m_v[2];
    logic        m_sof[2];
    logic        m_ovf[2];
    int          m_drop[2];

    nonce_serial_fifo #(.NONCE_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0), .DROP_W(8)) u_a (
        .clk(clk), .rst(rst), .valid(valid), .success(success), .nonce_i(nonce_i),
        .readready(readready), .nonce_o(a_o), .nonce_valid(a_v), .sof(a_sof),
        .count(a_count), .empty(a_empty), .full(a_full), .overflow(a_ovf), .drop_count(a_drop)
    );

    nonce_serial_fifo #(.NONCE_WIDTH(32), .DEPTH(3), .MSB_FIRST(1'b1), .DROP_W(2)) u_b (
        .clk(clk), .rst(rst), .valid(valid), .success(success), .nonce_i(nonce_i),
        .readready(readready), .nonce_o(b_o), .nonce_valid(b_v), .sof(b_sof),
        .count(b_count), .empty(b_empty), .full(b_full), .overflow(b_ovf), .drop_count(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        mq[k].delete();
        mbit[k]   = 0;
        m_o[k]    = 1'b0;
        m_v[k]    = 1'b0;
        m_sof[k]  = 1'b0;
        m_ovf[k]  = 1'b0;
        m_drop[k] = 0;
    endtask

    // Advance the model by one clock edge using the inputs that edge will see.
    task automatic model_step(input int k);
        int          n;
        int          dep;
        int          dmax;
        int          idx;
        bit          emit;
        bit          pop;
        logic [31:0] w;
        if (!rst) begin
            model_reset(k);
            return;
        end
        dep  = (k == 0) ? 4 : 3;
        dmax = (k == 0) ? 255 : 3;
        n    = mq[k].size();
        emit = readready && (n > 0);
        pop  = emit && (mbit[k] == 31);
        if (emit) begin
            w        = mq[k][0];
            idx      = (k == 1) ? (31 - mbit[k]) : mbit[k];
            m_o[k]   = w[idx];
            m_v[k]   = 1'b1;
            m_sof[k] = (mbit[k] == 0);
            mbit[k]  = pop ? 0 : mbit[k] + 1;
        end else begin
            m_o[k]   = 1'b0;
            m_v[k]   = 1'b0;
            m_sof[k] = 1'b0;
        end
        if (valid && success) begin
            if ((n - int'(pop)) < dep) begin
                mq[k].push_back(nonce_i);
            end else begin
                m_ovf[k] = 1'b1;
                if (m_drop[k] < dmax) m_drop[k]++;
            end
        end
        if (pop) void'(mq[k].pop_front());
    endtask

    task automatic compare_all();
        chk("a_nonce_o",     32'(a_o),     32'(m_o[0]));
        chk("a_nonce_valid", 32'(a_v),     32'(m_v[0]));
        chk("a_sof",         32'(a_sof),   32'(m_sof[0]));
        chk("a_count",       32'(a_count), mq[0].size());
        chk("a_empty",       32'(a_empty), 32'(mq[0].size() == 0));
        chk("a_full",        32'(a_full),  32'(mq[0].size() == 4));
        chk("a_overflow",    32'(a_ovf),   32'(m_ovf[0]));
        chk("a_drop_count",  32'(a_drop),  m_drop[0]);
        chk("b_nonce_o",     32'(b_o),     32'(m_o[1]));
        chk("b_nonce_valid", 32'(b_v),     32'(m_v[1]));
        chk("b_sof",         32'(b_sof),   32'(m_sof[1]));
        chk("b_count",       32'(b_count), mq[1].size());
        chk("b_empty",       32'(b_empty), 32'(mq[1].size() == 0));
        chk("b_full",        32'(b_full),  32'(mq[1].size() == 3));
        chk("b_overflow",    32'(b_ovf),   32'(m_ovf[1]));
        chk("b_drop_count",  32'(b_drop),  m_drop[1]);
    endtask

    // One clock: model predicts, edge happens, outputs are sampled 1 time unit later.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic push_one(input logic [31:0] n);
        valid   = 1'b1;
        success = 1'b1;
        nonce_i = n;
        tick();
        valid   = 1'b0;
        success = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] w2;
        logic [31:0] pw[5];
        logic [31:0] x;
        logic        first_bit;
        logic        first_sof;
        int          nv;
        int          nsof;
        int          bad;
        int          ones_mid;

        rst = 1'b0; valid = 1'b0; success = 1'b0; nonce_i = '0; readready = 1'b0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_valid", 32'(a_v), 0);
        rst = 1'b1;

        // Idle with readready high and nothing queued
        readready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_v !== 1'b0 || a_empty !== 1'b1 || a_count !== 3'd0) bad++;
        end
        chk("idle_no_output", bad, 0);
        readready = 1'b0;

        // Single word, LSB first
        push_one(32'hA5A5_0F0F);
        readready = 1'b1;
        word = '0; nv = 0; nsof = 0; first_sof = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            word[i] = a_o;
            nv   += int'(a_v);
            nsof += int'(a_sof);
            if (i == 0) first_sof = a_sof;
            if (i == 30) chk("word_count_before_last", 32'(a_count), 1);
        end
        chk("word_bits", word, 32'hA5A5_0F0F);
        chk("word_low_byte", 32'(word[7:0]), 32'h0F);
        chk("word_valid_cycles", nv, 32);
        chk("word_sof_count", nsof, 1);
        chk("word_sof_first", 32'(first_sof), 1);
        chk("word_count_after", 32'(a_count), 0);
        readready = 1'b0;
        tick();

        // Back-to-back words
        push_one(32'h1);
        push_one(32'h2);
        readready = 1'b1;
        word = '0; w2 = '0; nv = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i < 32) word[i] = a_o;
            else w2[i-32] = a_o;
            nv += int'(a_v);
            if (a_sof !== ((i == 0) || (i == 32))) bad++;
        end
        chk("b2b_word0", word, 32'h1);
        chk("b2b_word1", w2, 32'h2);
        chk("b2b_valid_cycles", nv, 64);
        chk("b2b_sof_positions", bad, 0);
        readready = 1'b0;
        tick();

        // Overfill: 5 pushes into depth 4 (and depth 3 on the second instance)
        for (int k = 0; k < 5; k++) begin
            pw[k] = $urandom;
            push_one(pw[k]);
        end
        chk("ovf_full", 32'(a_full), 1);
        chk("ovf_flag", 32'(a_ovf), 1);
        chk("ovf_drop", 32'(a_drop), 1);
        chk("ovf_count", 32'(a_count), 4);
        chk("ovf_drop_depth3", 32'(b_drop), 2);
        readready = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            word = '0;
            for (int i = 0; i < 32; i++) begin
                tick();
                word[i] = a_o;
            end
            if (word !== pw[k]) bad++;
        end
        chk("ovf_readout_words", bad, 0);
        readready = 1'b0;
        tick();

        // Mid-word pause
        x = $urandom;
        push_one(x);
        readready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        readready = 1'b0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (a_v !== 1'b0) bad++;
        end
        chk("pause_silent", bad, 0);
        readready = 1'b1;
        tick();
        chk("pause_resume_bit", 32'(a_o), 32'(x[11]));
        chk("pause_resume_sof", 32'(a_sof), 0);
        chk("pause_resume_valid", 32'(a_v), 1);
        for (int i = 0; i < 20; i++) tick();
        readready = 1'b0;
        tick();

        // Asynchronous reset in the middle of a word
        push_one(32'h1234_5678);
        readready = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        #2;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("arst_nonce_o", 32'(a_o), 0);
        chk("arst_valid", 32'(a_v), 0);
        chk("arst_sof", 32'(a_sof), 0);
        chk("arst_count", 32'(a_count), 0);
        chk("arst_overflow", 32'(a_ovf), 0);
        chk("arst_drop", 32'(a_drop), 0);
        readready = 1'b0;
        tick();
        rst = 1'b1;
        push_one(32'hFFFF_FFFF);
        readready = 1'b1;
        word = '0; first_sof = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            word[i] = a_o;
            if (i == 0) first_sof = a_sof;
        end
        chk("post_rst_word", word, 32'hFFFF_FFFF);
        chk("post_rst_sof", 32'(first_sof), 1);
        readready = 1'b0;
        tick();

        // Full FIFO accepts a capture on the edge that pops the last bit
        for (int k = 0; k < 4; k++) push_one(32'h100 + 32'(k));
        chk("pp_full_before", 32'(a_full), 1);
        x = 32'hC0DE_0007;
        readready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                valid = 1'b1; success = 1'b1; nonce_i = x;
            end
            tick();
            valid = 1'b0; success = 1'b0;
        end
        chk("pp_count", 32'(a_count), 4);
        chk("pp_overflow", 32'(a_ovf), 0);
        chk("pp_full", 32'(a_full), 1);
        for (int k = 0; k < 4; k++) begin
            word = '0;
            for (int i = 0; i < 32; i++) begin
                tick();
                word[i] = a_o;
            end
        end
        chk("pp_last_word", word, x);
        readready = 1'b0;
        tick();

        // MSB-first instance on 0x8000_0001
        push_one(32'h8000_0001);
        readready = 1'b1;
        ones_mid = 0; first_bit = 1'b0; first_sof = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) begin
                first_bit = b_o;
                first_sof = b_sof;
            end else if (i < 31) begin
                ones_mid += int'(b_o);
            end else begin
                chk("msb_last_bit", 32'(b_o), 1);
            end
        end
        chk("msb_first_bit", 32'(first_bit), 1);
        chk("msb_first_sof", 32'(first_sof), 1);
        chk("msb_middle_zeros", ones_mid, 0);
        readready = 1'b0;
        tick();

        // Randomized traffic including occasional resets
        for (int c = 0; c < 3000; c++) begin
            readready = ($urandom_range(0, 9) < 7);
            valid     = ($urandom_range(0, 2) == 0);
            success   = ($urandom_range(0, 1) == 0);
            nonce_i   = $urandom;
            rst       = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst = 1'b1;
        valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
